// File: rtl/rpn_sequencer_if.sv
// Token and result handshake bundle for the RPN sequencer.
interface rpn_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             tok_valid;
  logic             tok_ready;
  logic [1:0]       tok_kind;
  logic             tok_op;
  logic [WIDTH-1:0] tok_data;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ready;

  // Token/result producer-consumer side
  modport master (
    output tok_valid, tok_kind, tok_op, tok_data, res_ready,
    input  tok_ready, res_valid, res_data
  );

  // Sequencer side
  modport slave (
    input  tok_valid, tok_kind, tok_op, tok_data, res_ready,
    output tok_ready, res_valid, res_data
  );
endinterface

// File: rtl/rpn_sequencer.sv
// RPN token sequencer: operand stack plus an external single-cycle ALU.
// Operands are pushed, operators pop two entries through the ALU and push
// the result, and an end token with exactly one entry left yields the result.
// DEPTH must be a power of two and at least 2.
module rpn_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  rpn_sequencer_if.slave         bus,
  output logic                   alu_h,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  input  logic [WIDTH-1:0]       alu_result,
  output logic                   err,
  output logic [$clog2(DEPTH):0] depth
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = AW + 1;

  localparam logic [1:0] KIND_OPND = 2'b00;
  localparam logic [1:0] KIND_OPER = 2'b01;
  localparam logic [1:0] KIND_END  = 2'b10;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    EXEC   = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             alu_h_q, alu_h_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic             tok_ready_c;

  // Tokens are only taken while idle in ACCEPT and not being flushed
  assign tok_ready_c = (state_q == ACCEPT) && !clear;

  // Next-state, stack update and registered-output computation
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    alu_h_d     = alu_h_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = err_q;
    stack_d     = stack_q;

    if (clear) begin
      state_d     = ACCEPT;
      depth_d     = '0;
      res_valid_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (bus.tok_valid) begin
            case (bus.tok_kind)
              KIND_OPND: begin
                if (depth_q == DW'(DEPTH)) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                end else begin
                  stack_d[AW'(depth_q)] = bus.tok_data;
                  depth_d               = depth_q + DW'(1);
                end
              end
              KIND_OPER: begin
                if (depth_q >= DW'(2)) begin
                  alu_a_d = stack_q[AW'(depth_q - DW'(2))];
                  alu_b_d = stack_q[AW'(depth_q - DW'(1))];
                  alu_h_d = bus.tok_op;
                  state_d = EXEC;
                end else begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                end
              end
              KIND_END: begin
                if (depth_q == DW'(1)) begin
                  res_data_d  = stack_q[0];
                  res_valid_d = 1'b1;
                  state_d     = DONE;
                end else begin
                  state_d = ERROR;
                  err_d   = 1'b1;
                end
              end
              default: begin
                state_d = ERROR;
                err_d   = 1'b1;
              end
            endcase
          end
        end
        EXEC: begin
          stack_d[AW'(depth_q - DW'(2))] = alu_result;
          depth_d                        = depth_q - DW'(1);
          state_d                        = ACCEPT;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_d = 1'b0;
            depth_d     = '0;
            state_d     = ACCEPT;
          end
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCEPT;
      depth_q     <= '0;
      alu_h_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      alu_h_q     <= alu_h_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

  // Operand stack storage; entries above depth are don't-care, so no reset
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.tok_ready = tok_ready_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign alu_h         = alu_h_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign err           = err_q;
  assign depth         = depth_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer: directed scenarios plus random
// expressions checked against a queue-based RPN evaluator.
module tb_rpn_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 8;
  localparam int unsigned DW = $clog2(D) + 1;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          alu_h;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_result;
  logic          err;
  logic [DW-1:0] depth;

  logic          alu_force;
  logic [W-1:0]  alu_force_val;

  int total;
  int bad;

  rpn_sequencer_if #(.WIDTH(W)) bus ();

  rpn_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus.slave),
    .alu_h      (alu_h),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .err        (err),
    .depth      (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: op 0 adds, op 1 subtracts, optionally overridden by a fixed value
  assign alu_result = alu_force ? alu_force_val
                    : (alu_h ? W'(alu_a - alu_b) : W'(alu_a + alu_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a token, wait (bounded) until it is taken, then withdraw it
  task automatic send(input logic [1:0] k, input logic o, input logic [W-1:0] d);
    int n;
    n = 0;
    bus.tok_kind  = k;
    bus.tok_op    = o;
    bus.tok_data  = d;
    bus.tok_valid = 1'b1;
    while (!bus.tok_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(bus.tok_ready), 32'd1);
    tick();
    bus.tok_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #0;
    check("ready_low_in_clear", 32'(bus.tok_ready), 32'd0);
    tick();
    clear = 1'b0;
    #1;
    check("clear_err", 32'(err), 32'd0);
    check("clear_depth", 32'(depth), 32'd0);
    check("clear_ready", 32'(bus.tok_ready), 32'd1);
  endtask

  task automatic drain();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("drain_valid", 32'(bus.res_valid), 32'd0);
    check("drain_depth", 32'(depth), 32'd0);
    check("drain_ready", 32'(bus.tok_ready), 32'd1);
  endtask

  logic [W-1:0] q[$];

  // One random expression evaluated by a plain RPN stack model
  task automatic random_expr();
    int ntok;
    int cnt;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] v;
    logic         o;
    q.delete();
    ntok = $urandom_range(1, 12);
    cnt  = 0;
    while (cnt < ntok || q.size() > 1) begin
      repeat ($urandom_range(0, 2)) tick();
      if (q.size() < 2 || (cnt < ntok && q.size() < D && $urandom_range(0, 1) == 1)) begin
        v = W'($urandom);
        send(2'b00, 1'b0, v);
        q.push_back(v);
        check("rnd_push_depth", 32'(depth), 32'(q.size()));
      end else begin
        o = 1'($urandom_range(0, 1));
        send(2'b01, o, W'($urandom));
        b = q.pop_back();
        a = q.pop_back();
        check("rnd_exec_ready", 32'(bus.tok_ready), 32'd0);
        check("rnd_alu_a", 32'(alu_a), 32'(a));
        check("rnd_alu_b", 32'(alu_b), 32'(b));
        check("rnd_alu_h", 32'(alu_h), 32'(o));
        q.push_back(o ? W'(a - b) : W'(a + b));
        tick();
        check("rnd_op_depth", 32'(depth), 32'(q.size()));
      end
      cnt++;
    end
    send(2'b10, 1'b0, '0);
    check("rnd_res_valid", 32'(bus.res_valid), 32'd1);
    check("rnd_res_data", 32'(bus.res_data), 32'(q[0]));
    repeat ($urandom_range(0, 3)) tick();
    check("rnd_res_hold", 32'(bus.res_data), 32'(q[0]));
    drain();
  endtask

  // Random protocol error followed by recovery through clear
  task automatic random_error();
    case ($urandom_range(0, 2))
      0: send(2'b11, 1'b0, W'($urandom));
      1: begin
        send(2'b00, 1'b0, W'($urandom));
        send(2'b00, 1'b0, W'($urandom));
        send(2'b10, 1'b0, '0);
      end
      default: begin
        send(2'b00, 1'b0, W'($urandom));
        send(2'b01, 1'($urandom), '0);
      end
    endcase
    check("rnd_err", 32'(err), 32'd1);
    check("rnd_err_ready", 32'(bus.tok_ready), 32'd0);
    tick();
    check("rnd_err_sticky", 32'(err), 32'd1);
    do_clear();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    alu_force     = 1'b0;
    alu_force_val = '0;
    bus.tok_valid = 1'b0;
    bus.tok_kind  = 2'b00;
    bus.tok_op    = 1'b0;
    bus.tok_data  = '0;
    bus.res_ready = 1'b0;

    #12;
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_h", 32'(alu_h), 32'd0);
    #10;
    rst_n = 1'b1;

    // 96 3 op1 with stubbed result 12; first token taken at first edge
    send(2'b00, 1'b0, W'(96));
    check("first_push_depth", 32'(depth), 32'd1);
    send(2'b00, 1'b0, W'(3));
    alu_force     = 1'b1;
    alu_force_val = W'(12);
    send(2'b01, 1'b1, '0);
    check("s1_alu_a", 32'(alu_a), 32'd96);
    check("s1_alu_b", 32'(alu_b), 32'd3);
    check("s1_alu_h", 32'(alu_h), 32'd1);
    tick();
    alu_force = 1'b0;
    check("s1_depth", 32'(depth), 32'd1);
    check("s1_alu_hold", 32'(alu_a), 32'd96);
    send(2'b10, 1'b0, '0);
    check("s1_res_valid", 32'(bus.res_valid), 32'd1);
    check("s1_res_data", 32'(bus.res_data), 32'd12);
    drain();

    // Operator latency: 4 4 op0
    send(2'b00, 1'b0, W'(4));
    send(2'b00, 1'b0, W'(4));
    send(2'b01, 1'b0, '0);
    check("s2_ready_lat1", 32'(bus.tok_ready), 32'd0);
    tick();
    check("s2_ready_lat2", 32'(bus.tok_ready), 32'd1);
    send(2'b10, 1'b0, '0);
    check("s2_res_data", 32'(bus.res_data), 32'd8);
    drain();

    // Underflowing operator, then clear
    send(2'b00, 1'b0, W'(5));
    send(2'b01, 1'b0, '0);
    check("s3_err", 32'(err), 32'd1);
    check("s3_ready", 32'(bus.tok_ready), 32'd0);
    check("s3_depth", 32'(depth), 32'd1);
    tick();
    check("s3_err_sticky", 32'(err), 32'd1);
    do_clear();

    // Clear beats EXEC write-back and a pending token
    send(2'b00, 1'b0, W'(1));
    send(2'b00, 1'b0, W'(2));
    send(2'b01, 1'b0, '0);
    bus.tok_valid = 1'b1;
    bus.tok_kind  = 2'b00;
    do_clear();
    bus.tok_valid = 1'b0;

    // Overflow and end with two entries
    for (int i = 0; i < int'(D); i++) send(2'b00, 1'b0, W'(i + 1));
    check("s4_full_depth", 32'(depth), 32'(D));
    check("s4_full_err", 32'(err), 32'd0);
    send(2'b00, 1'b0, W'(99));
    check("s4_ovf_err", 32'(err), 32'd1);
    check("s4_ovf_depth", 32'(depth), 32'(D));
    do_clear();
    send(2'b00, 1'b0, W'(1));
    send(2'b00, 1'b0, W'(2));
    send(2'b10, 1'b0, '0);
    check("s4_end2_err", 32'(err), 32'd1);
    check("s4_end2_valid", 32'(bus.res_valid), 32'd0);
    do_clear();

    // Result held while res_ready is low
    send(2'b00, 1'b0, W'(7));
    send(2'b10, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s5_hold_valid", 32'(bus.res_valid), 32'd1);
      check("s5_hold_data", 32'(bus.res_data), 32'd7);
      check("s5_hold_ready", 32'(bus.tok_ready), 32'd0);
    end
    drain();

    // Reset asserted mid-EXEC
    send(2'b00, 1'b0, W'(10));
    send(2'b00, 1'b0, W'(20));
    send(2'b01, 1'b1, '0);
    check("s6_exec_a", 32'(alu_a), 32'd10);
    #1;
    rst_n = 1'b0;
    #1;
    check("s6_rst_alu_a", 32'(alu_a), 32'd0);
    check("s6_rst_alu_b", 32'(alu_b), 32'd0);
    check("s6_rst_alu_h", 32'(alu_h), 32'd0);
    check("s6_rst_depth", 32'(depth), 32'd0);
    check("s6_rst_err", 32'(err), 32'd0);
    check("s6_rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("s6_rst_res_data", 32'(bus.res_data), 32'd0);
    tick();
    check("s6_rst_depth_edge", 32'(depth), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("s6_post_depth", 32'(depth), 32'd0);
    send(2'b00, 1'b0, W'(9));
    check("s6_post_push", 32'(depth), 32'd1);
    send(2'b10, 1'b0, '0);
    check("s6_post_res", 32'(bus.res_data), 32'd9);
    drain();

    // Random expressions with occasional protocol errors
    for (int e = 0; e < 60; e++) begin
      if (e % 5 == 4) random_error();
      else random_expr();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rpn_sequencer.md
RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand, result and stack-entry width.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of operand stack entries; DEPTH SHALL be a power of two.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have port clear  in  1  synchronous flush of stack and state.
REQ-005 The block SHALL have the token input ports: tok_valid  in  1  token offered; tok_ready  out  1  token accepted this cycle when high with tok_valid.
REQ-006 The block SHALL have the token content ports: tok_kind  in  2  00 operand, 01 operator, 10 end, 11 reserved; tok_op  in  1  operator select; tok_data  in  WIDTH  operand value.
REQ-007 The block SHALL have the ALU-drive ports: alu_h  out  1  ALU op select; alu_a  out  WIDTH  first (deeper) operand; alu_b  out  WIDTH  second (top) operand; alu_result  in  WIDTH  combinational ALU output.
REQ-008 The block SHALL have the result ports: res_valid  out  1  final result available; res_data  out  WIDTH  final result; res_ready  in  1  consumer takes result.
REQ-009 The block SHALL have the status ports: err  out  1  sticky error flag; depth  out  clog2(DEPTH)+1  current stack occupancy.

Function
REQ-010 The FSM SHALL have exactly the states ACCEPT, EXEC, DONE and ERROR.
REQ-011 tok_ready SHALL equal (state==ACCEPT) AND NOT clear, and no token SHALL be consumed in any other state.
REQ-012 In ACCEPT, an accepted operand SHALL be written to stack[depth] with depth incremented by 1 on the same edge.
REQ-013 An accepted operand while depth==DEPTH SHALL leave the stack unchanged and move the FSM to ERROR.
REQ-014 In ACCEPT, an accepted operator with depth>=2 SHALL register alu_a<=stack[depth-2], alu_b<=stack[depth-1] and alu_h<=tok_op, and move the FSM to EXEC.
REQ-015 An accepted operator with depth<2 SHALL move the FSM to ERROR with the stack unchanged.
REQ-016 EXEC SHALL last exactly one cycle, and at its closing edge stack[depth-2]<=alu_result, depth<=depth-1, and the FSM returns to ACCEPT.
REQ-017 Operator latency SHALL be exactly 2 cycles from acceptance to the next tok_ready high.
REQ-018 alu_a, alu_b and alu_h SHALL hold their values outside EXEC.
REQ-019 An accepted end token with depth==1 SHALL register res_data<=stack[0] and res_valid<=1 and move the FSM to DONE.
REQ-020 An accepted end token with depth!=1 SHALL move the FSM to ERROR.
REQ-021 An accepted tok_kind==11 token SHALL move the FSM to ERROR.
REQ-022 In DONE, res_valid and res_data SHALL be held stable until res_ready is high.
REQ-023 On the edge where DONE and res_ready are both high, res_valid SHALL go to 0, depth to 0, and the FSM to ACCEPT.
REQ-024 On entry to ERROR, err SHALL go to 1, and in ERROR err SHALL stay 1, tok_ready SHALL stay 0, and only clear SHALL exit.
REQ-025 clear high at an edge SHALL, in any state, set depth=0, res_valid=0 and err=0 and move the FSM to ACCEPT, with clear taking priority over any token, EXEC write-back or res_ready at the same edge.
REQ-026 Arithmetic SHALL be WIDTH bits with no sign or overflow interpretation, and alu_result SHALL be stored unmodified.
REQ-027 Stack contents beyond depth SHALL be don't-care and need not be reset.

Reset
REQ-028 While rst_n is low, the block SHALL asynchronously force state=ACCEPT, depth=0, alu_h=0, alu_a=0, alu_b=0, res_valid=0, res_data=0 and err=0.
REQ-029 Reset asserted mid-EXEC or in DONE SHALL discard the operation and result without write-back.
REQ-030 The first token SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-031 The bench SHALL cover: operand 96, operand 3, operator tok_op=1 -> in EXEC alu_a=96, alu_b=3, alu_h=1; stub alu_result=12 -> depth=1; end -> res_valid=1, res_data=12.
REQ-032 The bench SHALL cover: operands 4, 4 then operator tok_op=0 -> tok_ready low exactly one cycle after acceptance and high again 2 cycles after acceptance.
REQ-033 The bench SHALL cover: operator with depth=1 -> err=1, tok_ready=0; clear -> err=0, depth=0, tok_ready=1.
REQ-034 The bench SHALL cover: DEPTH+1 operands -> the last push goes to ERROR and depth stays DEPTH; end token with depth=2 -> ERROR.
REQ-035 The bench SHALL cover: result in DONE with res_ready=0 for 3 cycles -> res_valid and res_data stable; res_ready=1 -> res_valid=0 next cycle.
REQ-036 The bench SHALL cover: rst_n low during EXEC -> all outputs 0 immediately, depth=0, and no stack write-back.
